// File: rtl/xor_stream_decrypt.sv
// Receive-side byte decryptor: XORs each accepted ciphertext byte with an 8-bit
// maximal-length LFSR keystream and holds the result in a one-entry output register.
module xor_stream_decrypt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_load,
   input  logic [7:0]  key,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        keyed,
   output logic [15:0] byte_count
);

   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   typedef enum logic {UNKEYED, KEYED} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] s;
   logic              in_xfer;

   // Taps 8,6,5,4 give a period of 255; the all-zero state is never entered.
   function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [DATA_W-1:0] seed_of(input logic [DATA_W-1:0] k);
      return (k == '0) ? {DATA_W{1'b1}} : k;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= UNKEYED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (key_load) state_nxt = KEYED;
   end

   always_comb begin
      keyed = (state == KEYED);
   end

   assign in_ready = keyed && !key_load && (!out_valid || out_ready);
   assign in_xfer  = in_valid && in_ready;

   // Keystream and counter: a key load overrides any advance in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s          <= {DATA_W{1'b1}};
         byte_count <= '0;
      end else if (key_load) begin
         s          <= seed_of(key);
         byte_count <= '0;
      end else if (in_xfer) begin
         s          <= lfsr_next(s);
         byte_count <= byte_count + CNT_W'(1);
      end
   end

   // Output register: a simultaneous pop and push keeps out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (in_xfer) begin
         out_data  <= in_data ^ s;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Bench for xor_stream_decrypt: table vectors plus hand-written corner sequences,
// with a scoreboard queue filled on input acceptance and drained on output transfer.
module tb_xor_stream_decrypt;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_load;
   logic [7:0]  key;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        keyed;
   logic [15:0] byte_count;

   typedef struct {
      logic       chk;
      logic [7:0] val;
   } exp_t;

   typedef struct {
      logic [7:0] key;
      logic [7:0] ct;
      logic [7:0] pt;
   } vec_t;

   exp_t       sb[$];
   logic [7:0] out_log[$];
   int         checks   = 0;
   int         failures = 0;

   xor_stream_decrypt dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key        (key),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .keyed      (keyed),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Scoreboard drain: every output transfer must match the oldest accepted byte.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && out_valid && out_ready) begin
         out_log.push_back(out_data);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected act=%02h exp=none", out_data);
         end else begin
            e = sb.pop_front();
            if (e.chk) check("sb_out", {8'h00, out_data}, {8'h00, e.val});
         end
      end
   end

   task automatic load_key(input logic [7:0] k);
      key_load = 1'b1;
      key      = k;
      @(posedge clk); #1;
      key_load = 1'b0;
   endtask

   task automatic send(input logic [7:0] ct, input logic [7:0] pt, input logic c);
      int   n;
      exp_t e;
      n        = 0;
      in_data  = ct;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout act=in_ready_0 exp=in_ready_1");
      end else begin
         e.chk = c;
         e.val = pt;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t       vecs[6];
      logic [7:0] ks6[6];
      int         ones;

      vecs[0] = '{key: 8'h01, ct: 8'h40, pt: 8'h41};
      vecs[1] = '{key: 8'h00, ct: 8'h00, pt: 8'hFF};
      vecs[2] = '{key: 8'hFF, ct: 8'h0F, pt: 8'hF0};
      vecs[3] = '{key: 8'hA5, ct: 8'hA5, pt: 8'h00};
      vecs[4] = '{key: 8'h80, ct: 8'h01, pt: 8'h81};
      vecs[5] = '{key: 8'h3C, ct: 8'hFF, pt: 8'hC3};
      ks6 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

      rst_n = 1'b0; key_load = 1'b0; key = 8'h00;
      in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_in_ready",   {15'd0, in_ready},  16'h0);
      check("rst_out_valid",  {15'd0, out_valid}, 16'h0);
      check("rst_out_data",   {8'h00, out_data},  16'h0);
      check("rst_keyed",      {15'd0, keyed},     16'h0);
      check("rst_byte_count", byte_count,         16'h0);
      rst_n = 1'b1;

      // Unkeyed: input is refused indefinitely.
      in_valid = 1'b1; in_data = 8'h5A;
      repeat (8) begin
         @(negedge clk);
         check("unkeyed_in_ready",  {15'd0, in_ready},  16'h0);
         check("unkeyed_keyed",     {15'd0, keyed},     16'h0);
         check("unkeyed_out_valid", {15'd0, out_valid}, 16'h0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;

      // Keystream from seed 01 at full throughput.
      out_ready = 1'b1;
      load_key(8'h01);
      check("key_keyed",      {15'd0, keyed}, 16'h1);
      check("key_byte_count", byte_count,     16'h0);
      for (int i = 0; i < 6; i++) send(8'h00, ks6[i], 1'b1);
      idle(2);
      check("stream_byte_count", byte_count,         16'd6);
      check("stream_out_valid",  {15'd0, out_valid}, 16'h0);
      check("stream_drained",    16'(sb.size()),     16'h0);

      for (int i = 0; i < 6; i++) begin
         load_key(vecs[i].key);
         send(vecs[i].ct, vecs[i].pt, 1'b1);
         idle(2);
         check("tbl_byte_count", byte_count,     16'd1);
         check("tbl_drained",    16'(sb.size()), 16'h0);
      end

      load_key(8'h01);
      send(8'h40, 8'h41, 1'b1);
      send(8'h40, 8'h42, 1'b1);
      idle(2);
      check("pair_byte_count", byte_count, 16'd2);

      // Backpressure: output holds, nothing accepted, keystream not skipped.
      load_key(8'h01);
      out_ready = 1'b0;
      send(8'h00, 8'h01, 1'b1);
      in_valid = 1'b1; in_data = 8'h00;
      repeat (3) begin
         @(negedge clk);
         check("bp_out_valid",  {15'd0, out_valid}, 16'h1);
         check("bp_out_data",   {8'h00, out_data},  16'h01);
         check("bp_in_ready",   {15'd0, in_ready},  16'h0);
         check("bp_byte_count", byte_count,         16'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'h00, 8'h02, 1'b1);
      idle(2);
      check("bp_release_count", byte_count, 16'd2);

      // key_load collides with in_valid while an output is pending.
      load_key(8'h01);
      out_ready = 1'b0;
      send(8'h00, 8'h01, 1'b1);
      key_load = 1'b1; key = 8'h80; in_valid = 1'b1; in_data = 8'h00;
      @(negedge clk);
      check("kl_in_ready", {15'd0, in_ready}, 16'h0);
      @(posedge clk); #1;
      key_load = 1'b0; in_valid = 1'b0;
      check("kl_out_valid",  {15'd0, out_valid}, 16'h1);
      check("kl_out_data",   {8'h00, out_data},  16'h01);
      check("kl_byte_count", byte_count,         16'h0);
      out_ready = 1'b1;
      send(8'h00, 8'h80, 1'b1);
      idle(2);
      check("kl_new_seed_count", byte_count, 16'd1);

      // Back-to-back key loads: the last seed wins.
      key_load = 1'b1; key = 8'h55;
      @(posedge clk); #1;
      key = 8'h01;
      @(posedge clk); #1;
      key_load = 1'b0;
      check("b2b_byte_count", byte_count, 16'h0);
      send(8'h00, 8'h01, 1'b1);
      idle(2);

      // Asynchronous reset mid-cycle with a pending output.
      load_key(8'h01);
      out_ready = 1'b0;
      send(8'h00, 8'h01, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid",  {15'd0, out_valid}, 16'h0);
      check("arst_keyed",      {15'd0, keyed},     16'h0);
      check("arst_byte_count", byte_count,         16'h0);
      check("arst_in_ready",   {15'd0, in_ready},  16'h0);
      check("arst_out_data",   {8'h00, out_data},  16'h0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Period: 255 advances from seed 01 return to 01 and not earlier.
      load_key(8'h01);
      out_log.delete();
      for (int i = 0; i < 256; i++) begin
         if (i < 6)         send(8'h00, ks6[i], 1'b1);
         else if (i == 255) send(8'h00, 8'h01, 1'b1);
         else               send(8'h00, 8'h00, 1'b0);
      end
      idle(2);
      check("period_count",      byte_count,          16'h0100);
      check("period_log_size",   16'(out_log.size()), 16'd256);
      ones = 0;
      for (int i = 1; i < 255 && i < out_log.size(); i++)
         if (out_log[i] == 8'h01) ones++;
      check("period_no_early_01", 16'(ones),          16'h0);
      check("final_drained",      16'(sb.size()),     16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xor_stream_decrypt.md
# xor_stream_decrypt

Byte-stream decryptor for the special-purpose processor datapath. Ciphertext bytes are XORed with an 8-bit LFSR keystream, one byte per accepted transfer. The block is the receive-side counterpart of the byte-wise XOR encryption stage. It sits between the input byte source and the processor's data consumer, with valid/ready handshakes on both sides and a one-entry output register.

## Interface
- No parameters. The data width is fixed at 8 bits and the counter width at 16 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_load  input  1  one-cycle pulse: load the keystream seed from key.
- key  input  8  seed value, sampled when key_load=1.
- in_data  input  8  ciphertext byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  8  plaintext byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- keyed  output  1  a seed has been loaded since reset.
- byte_count  output  16  plaintext bytes produced since the last key_load.

## Operation
- FSM has two states, UNKEYED and KEYED.
  - Reset enters UNKEYED.
  - key_load=1 in any state moves to KEYED.
  - There is no other transition.
  - keyed=1 exactly in KEYED.
- The keystream register is s[7:0].
  - On key_load, s <= key. If key==8'h00, s <= 8'hFF instead, because the all-zero state is forbidden.
  - Advance: fb = s[7]^s[5]^s[4]^s[3]; s <= {s[6:0], fb}. This is maximal length, period 255.
  - Keystream byte for the current transfer = s before the advance.
- Input transfer occurs when in_valid && in_ready. On a transfer:
  - out_data <= in_data ^ s
  - out_valid <= 1
  - s advances once
  - byte_count increments, wrapping 16'hFFFF -> 16'h0000
- Output transfer occurs when out_valid && out_ready. It clears out_valid unless a new input transfer happens in the same cycle; in that case out_valid stays 1 and out_data takes the new byte.
- in_ready = keyed && !key_load && (!out_valid || out_ready). This gives full throughput, one byte per cycle, when out_ready is held high.
- key_load has priority over everything else:
  - No input transfer in that cycle, because in_ready is 0.
  - s reloads and byte_count <= 0.
  - The pending out_data/out_valid is untouched and is still delivered normally.
- in_data is ignored while UNKEYED; in_ready=0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=8'h00, keyed=0, byte_count=16'h0000, s=8'hFF, state UNKEYED.
- Latency: a byte accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle.
- key_load at edge N: keyed=1 after N. in_ready can be 1 in cycle N+1 if key_load has been deasserted.
- Back-to-back key_load pulses: the last pulse wins. byte_count stays 0.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid hold and in_ready=0. s and byte_count do not change.
- Reset asserted mid-stream: all state returns to its reset values immediately. The pending output is discarded and the block must be re-keyed.

## Test plan
- Reset, then in_valid=1 with no key_load -> in_ready=0 and keyed=0 indefinitely; out_valid stays 0.
- key_load with key=8'h01, then stream ciphertext 00,00,00,00,00,00 with out_ready=1 -> out_data 01,02,04,08,11,23 on consecutive cycles; byte_count=6.
- key=8'h01, ciphertext 41^01=40, 42^02=40 -> plaintext 41, 42. key_load with key=8'h00 -> first keystream byte FF.
- Backpressure: hold out_ready=0 for 3 cycles after the first byte -> out_data stable and in_ready=0. On release the next byte uses keystream 02, not a skipped value.
- key_load asserted together with in_valid while out_valid=1 -> no input accepted. The pending byte is delivered intact, byte_count=0, and the next byte uses the new seed.
- Assert rst_n=0 mid-stream -> out_valid=0, keyed=0, byte_count=0 asynchronously. 255 advances from seed 01 return s to 01, confirming the period.
